// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM demodulator: FSM states and timing constants.
package pdm_pkg;

    localparam int DEFAULT_WIN_LOG2 = 5;
    localparam int FLUSH_CYCLES     = 2;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        ACCUM
    } state_t;

endpackage

// File: rtl/pdm_sync2.sv
// Two-flop synchronizer bringing the asynchronous PDM bit into the clk domain.
module pdm_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pdm_demodulator.sv
// Counts ones of a synchronized PDM stream over back-to-back windows of
// 2^WIN_LOG2 samples and publishes the clamped count once per window.
module pdm_demodulator
    import pdm_pkg::*;
#(
    parameter int WIN_LOG2 = DEFAULT_WIN_LOG2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                pdm_in,
    output logic [WIN_LOG2-1:0] level,
    output logic                level_valid,
    output logic                saturated,
    output logic                busy
);

    localparam logic [WIN_LOG2-1:0] LAST_SAMPLE = '1;
    localparam logic [WIN_LOG2-1:0] MAX_LEVEL   = '1;
    localparam logic [WIN_LOG2-1:0] ONE_SAMPLE  = {{(WIN_LOG2-1){1'b0}}, 1'b1};
    localparam logic [WIN_LOG2:0]   FULL_SUM    = {1'b1, {WIN_LOG2{1'b0}}};
    localparam logic [1:0]          FLUSH_LAST  = 2'(FLUSH_CYCLES - 1);

    state_t              state;
    logic [1:0]          flush_cnt;
    logic [WIN_LOG2:0]   ones_cnt;
    logic [WIN_LOG2-1:0] sample_cnt;
    logic [WIN_LOG2:0]   sum;
    logic                sync_bit;

    pdm_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pdm_in),
        .q     (sync_bit)
    );

    // Running total including the sample taken on the current edge.
    assign sum  = ones_cnt + {{WIN_LOG2{1'b0}}, sync_bit};
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            flush_cnt   <= '0;
            ones_cnt    <= '0;
            sample_cnt  <= '0;
            level       <= '0;
            level_valid <= 1'b0;
            saturated   <= 1'b0;
        end else begin
            level_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state     <= FLUSH;
                        flush_cnt <= '0;
                    end
                end
                FLUSH: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (flush_cnt == FLUSH_LAST) begin
                        state      <= ACCUM;
                        ones_cnt   <= '0;
                        sample_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt + 2'd1;
                    end
                end
                ACCUM: begin
                    // Dropping enable wins even on the last-sample edge.
                    if (!enable) begin
                        state      <= IDLE;
                        ones_cnt   <= '0;
                        sample_cnt <= '0;
                    end else if (sample_cnt == LAST_SAMPLE) begin
                        level       <= (sum >= {1'b0, MAX_LEVEL}) ? MAX_LEVEL : sum[WIN_LOG2-1:0];
                        saturated   <= (sum == FULL_SUM);
                        level_valid <= 1'b1;
                        ones_cnt    <= '0;
                        sample_cnt  <= '0;
                    end else begin
                        ones_cnt   <= sum;
                        sample_cnt <= sample_cnt + ONE_SAMPLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_demodulator.sv
// Directed self-checking bench for pdm_demodulator at the default 32-sample window.
module tb_pdm_demodulator;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       pdm_in;
    logic [4:0] level;
    logic       level_valid;
    logic       saturated;
    logic       busy;

    int         checks;
    int         failures;
    int         mode;
    logic       const_bit;
    logic [4:0] sd_x;
    logic [4:0] sd_acc;
    int         n;
    int         p;

    pdm_demodulator dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pdm_in      (pdm_in),
        .level       (level),
        .level_valid (level_valid),
        .saturated   (saturated),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One clock edge, then sample outputs and drive the next PDM bit 1 ns later.
    // Mode 0 holds const_bit; mode 1 is a first-order sigma-delta of sd_x/32.
    task automatic step();
        logic [5:0] t;
        @(posedge clk);
        #1;
        if (mode == 0) begin
            pdm_in = const_bit;
        end else begin
            t      = {1'b0, sd_acc} + {1'b0, sd_x};
            sd_acc = t[4:0];
            pdm_in = t[5];
        end
    endtask

    task automatic wait_valid(input int limit, output int steps);
        bit found;
        found = 0;
        steps = 0;
        while (!found && steps < limit) begin
            step();
            steps++;
            if (level_valid) found = 1;
        end
        if (!found) steps = limit + 1;
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (level_valid) pulses++;
        end
    endtask

    initial begin
        clk = 0; reset = 1; enable = 0; pdm_in = 0;
        mode = 0; const_bit = 0; sd_x = '0; sd_acc = '0;
        checks = 0; failures = 0;

        repeat (3) step();
        checkOutput("reset_level", level, 0);
        checkOutput("reset_valid", level_valid, 0);
        checkOutput("reset_sat", saturated, 0);
        checkOutput("reset_busy", busy, 0);

        // All ones: first pulse on edge E0+34, seen after the 35th step counting E0.
        const_bit = 1;
        repeat (3) step();
        reset = 0;
        step();
        checkOutput("idle_busy", busy, 0);
        enable = 1;
        wait_valid(60, n);
        checkOutput("first_latency", n, 35);
        checkOutput("ones_level", level, 31);
        checkOutput("ones_sat", saturated, 1);
        checkOutput("run_busy", busy, 1);
        step();
        checkOutput("valid_single", level_valid, 0);
        wait_valid(40, n);
        checkOutput("period_ones", n, 31);

        // All zeros: the first window still holds synchronizer leftovers.
        const_bit = 0;
        wait_valid(40, n);
        wait_valid(40, n);
        checkOutput("period_zeros", n, 32);
        checkOutput("zeros_level", level, 0);
        checkOutput("zeros_sat", saturated, 0);

        mode = 1;
        sd_x = 5'h08;
        wait_valid(40, n);
        wait_valid(40, n);
        checkOutput("sd08_level_a", level, 8);
        checkOutput("sd08_sat", saturated, 0);
        wait_valid(40, n);
        checkOutput("sd08_level_b", level, 8);

        sd_x = 5'h1a;
        wait_valid(40, n);
        wait_valid(40, n);
        checkOutput("sd1a_level", level, 26);

        // Drop enable on the edge that takes sample 20.
        repeat (20) step();
        enable = 0;
        step();
        checkOutput("abort_busy", busy, 0);
        count_pulses(40, p);
        checkOutput("abort_pulses", p, 0);
        checkOutput("abort_hold_level", level, 26);
        enable = 1;
        wait_valid(60, n);
        checkOutput("reenable_latency", n, 35);
        checkOutput("reenable_level", level, 26);

        // Window content changes so a wrongly published level would differ from 26.
        mode = 0;
        const_bit = 0;
        repeat (31) step();
        enable = 0;
        step();
        checkOutput("last_edge_valid", level_valid, 0);
        checkOutput("last_edge_level", level, 26);
        checkOutput("last_edge_busy", busy, 0);
        count_pulses(10, p);
        checkOutput("last_edge_pulses", p, 0);

        mode = 1;
        enable = 1;
        wait_valid(60, n);
        checkOutput("restart_level", level, 26);
        repeat (10) step();
        #2 reset = 1;
        #1;
        checkOutput("async_level", level, 0);
        checkOutput("async_sat", saturated, 0);
        checkOutput("async_busy", busy, 0);
        checkOutput("async_valid", level_valid, 0);
        repeat (3) step();
        checkOutput("held_reset_busy", busy, 0);
        reset = 0;
        wait_valid(60, n);
        checkOutput("post_reset_latency", n, 35);
        checkOutput("post_reset_level", level, 26);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
